// File: rtl/commit_loop.sv
// Walks every (iteration, leaf) pair, launches one commit_hash run per visible leaf,
// skips the hidden leaf of each iteration and writes returned words to a flat buffer.
module commit_loop #(
  parameter string PARAMETER_SET = "L1",
  parameter int    LAMBDA        = (PARAMETER_SET == "L5") ? 256 : (PARAMETER_SET == "L3") ? 192 : 128,
  parameter int    TAU           = (PARAMETER_SET == "L5") ? 34 : (PARAMETER_SET == "L3") ? 26 : 17,
  parameter int    N_LEAVES      = 256,
  parameter int    COMMIT_SIZE   = LAMBDA,
  parameter int    COMMIT_WORDS  = COMMIT_SIZE / 32,
  parameter int    CM_AW         = $clog2(TAU * N_LEAVES * COMMIT_WORDS),
  parameter int    HID_AW        = (TAU > 1) ? $clog2(TAU) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_done,
  output logic              o_busy,
  output logic              o_error,
  output logic              o_hidden_rd,
  output logic [HID_AW-1:0] o_hidden_addr,
  input  logic [15:0]       i_hidden_leaf,
  output logic              o_ch_start,
  input  logic              i_ch_done,
  output logic [15:0]       o_iteration,
  output logic [15:0]       o_leaf_idx,
  output logic              o_last_commit,
  input  logic [31:0]       i_commit,
  input  logic              i_commit_valid,
  output logic [31:0]       o_cm_data,
  output logic [CM_AW-1:0]  o_cm_addr,
  output logic              o_cm_wen
);

  localparam int WW = $clog2(COMMIT_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH_HID, LOAD_HID, CHECK, START, COLLECT, NEXT, FIN
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [15:0]     iter_r;
  logic [15:0]     leaf_r;
  logic [15:0]     hid_r;
  logic [WW-1:0]   word_r;

  logic            in_collect_s;
  logic            word_room_s;
  logic            wr_s;
  logic            drop_s;
  logic [WW-1:0]   word_final_s;
  logic            short_s;
  logic            leaf_last_s;
  logic            iter_last_s;
  logic            last_cond_s;
  logic [CM_AW-1:0] addr_s;

  assign o_iteration   = iter_r;
  assign o_leaf_idx    = leaf_r;
  assign o_hidden_addr = iter_r[HID_AW-1:0];

  // Word acceptance, error conditions, end-of-walk flags and buffer address
  always_comb begin
    in_collect_s = (state_r == COLLECT);
    word_room_s  = (word_r < WW'(COMMIT_WORDS));
    wr_s         = in_collect_s && i_commit_valid && word_room_s;
    drop_s       = in_collect_s && i_commit_valid && !word_room_s;
    if (wr_s) begin
      word_final_s = word_r + WW'(1);
    end else begin
      word_final_s = word_r;
    end
    // a valid in the done cycle still counts toward the word total
    short_s     = in_collect_s && i_ch_done && (word_final_s != WW'(COMMIT_WORDS));
    leaf_last_s = (leaf_r == 16'(N_LEAVES - 1));
    iter_last_s = (iter_r == 16'(TAU - 1));
    last_cond_s = iter_last_s &&
                  (leaf_last_s ||
                   ((leaf_r == 16'(N_LEAVES - 2)) && (hid_r == 16'(N_LEAVES - 1))));
    addr_s = (CM_AW'(iter_r) * CM_AW'(N_LEAVES) + CM_AW'(leaf_r)) * CM_AW'(COMMIT_WORDS)
             + CM_AW'(word_r);
  end

  // Next-state decision for the leaf walk
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_start) begin
          state_next_s = FETCH_HID;
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH_HID: state_next_s = LOAD_HID;
      LOAD_HID:  state_next_s = CHECK;
      CHECK: begin
        if (leaf_r == hid_r) begin
          state_next_s = NEXT;
        end else begin
          state_next_s = START;
        end
      end
      START: state_next_s = COLLECT;
      COLLECT: begin
        if (i_ch_done) begin
          state_next_s = NEXT;
        end else begin
          state_next_s = COLLECT;
        end
      end
      NEXT: begin
        if (!leaf_last_s) begin
          state_next_s = CHECK;
        end else if (iter_last_s) begin
          state_next_s = FIN;
        end else begin
          state_next_s = FETCH_HID;
        end
      end
      FIN:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, counters and registered outputs; strobes are decoded from the next state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r       <= IDLE;
      iter_r        <= 16'd0;
      leaf_r        <= 16'd0;
      hid_r         <= 16'd0;
      word_r        <= '0;
      o_done        <= 1'b0;
      o_busy        <= 1'b0;
      o_error       <= 1'b0;
      o_hidden_rd   <= 1'b0;
      o_ch_start    <= 1'b0;
      o_last_commit <= 1'b0;
      o_cm_wen      <= 1'b0;
      o_cm_data     <= 32'd0;
      o_cm_addr     <= '0;
    end else begin
      state_r       <= state_next_s;
      o_busy        <= (state_next_s != IDLE);
      o_hidden_rd   <= (state_next_s == FETCH_HID);
      o_ch_start    <= (state_next_s == START);
      o_done        <= (state_next_s == FIN);
      o_last_commit <= ((state_next_s == START) || (state_next_s == COLLECT)) && last_cond_s;
      o_cm_wen      <= wr_s;
      if (wr_s) begin
        o_cm_data <= i_commit;
        o_cm_addr <= addr_s;
      end
      case (state_r)
        IDLE: begin
          if (i_start) begin
            iter_r  <= 16'd0;
            leaf_r  <= 16'd0;
            word_r  <= '0;
            o_error <= 1'b0;
          end
        end
        LOAD_HID: begin
          hid_r <= i_hidden_leaf;
          // an out-of-range index never matches a leaf, so nothing is skipped
          if (i_hidden_leaf >= 16'(N_LEAVES)) begin
            o_error <= 1'b1;
          end
        end
        CHECK: begin
          if (leaf_r != hid_r) begin
            word_r <= '0;
          end
        end
        COLLECT: begin
          if (wr_s) begin
            word_r <= word_r + WW'(1);
          end
          if (drop_s || short_s) begin
            o_error <= 1'b1;
          end
        end
        NEXT: begin
          if (leaf_last_s) begin
            leaf_r <= 16'd0;
            if (!iter_last_s) begin
              iter_r <= iter_r + 16'd1;
            end
          end else begin
            leaf_r <= leaf_r + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
